// File: rtl/servo_ramp.sv
// Servo motion sequencer: accepts a target/step/period from the E100 and walks the
// pwm compare value toward the target once per update tick, pushing each pair to pwm.
module servo_ramp #(
    parameter int UPDATE_CYCLES = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clock_valid,
    input  logic        ramp_command,
    output logic        ramp_response,
    input  logic [31:0] ramp_target,
    input  logic [31:0] ramp_step,
    input  logic [31:0] ramp_period,
    output logic [31:0] ramp_current,
    output logic        ramp_busy,
    output logic        pwm_command,
    input  logic        pwm_response,
    output logic [31:0] pwm_period,
    output logic [31:0] pwm_compare
);

    localparam int CW = (UPDATE_CYCLES > 2) ? $clog2(UPDATE_CYCLES) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(UPDATE_CYCLES - 1);

    localparam logic [2:0] S_RESET   = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_ACCEPT  = 3'd2;
    localparam logic [2:0] S_RESP    = 3'd3;
    localparam logic [2:0] S_STEP    = 3'd4;
    localparam logic [2:0] S_PUSH    = 3'd5;
    localparam logic [2:0] S_RELEASE = 3'd6;

    logic [2:0]    r_state;
    logic [31:0]   r_current;
    logic [31:0]   r_target;
    logic [31:0]   r_step;
    logic [31:0]   r_period;
    logic [CW-1:0] r_tickCount;
    logic          r_tickPending;
    logic          r_dirty;
    logic          r_rampResponse;
    logic [31:0]   r_rampCurrent;
    logic          r_pwmCommand;
    logic [31:0]   r_pwmPeriod;
    logic [31:0]   r_pwmCompare;

    logic          w_targetAbove;
    logic [31:0]   w_distance;
    logic [31:0]   w_nextCurrent;

    // Distance is always larger minus smaller, so the step decision never wraps.
    always_comb begin
        w_targetAbove = (r_target > r_current);
        w_distance    = w_targetAbove ? (r_target - r_current) : (r_current - r_target);
        w_nextCurrent = r_target;
        if ((r_step != 32'd0) && (w_distance > r_step)) begin
            w_nextCurrent = w_targetAbove ? (r_current + r_step) : (r_current - r_step);
        end
    end

    always_ff @(posedge clock) begin
        if (clock_valid) begin
            if (reset) begin
                r_state        <= S_RESET;
                r_current      <= '0;
                r_target       <= '0;
                r_step         <= '0;
                r_period       <= '0;
                r_tickCount    <= '0;
                r_tickPending  <= 1'b0;
                r_dirty        <= 1'b0;
                r_rampResponse <= 1'b0;
                r_rampCurrent  <= '0;
                r_pwmCommand   <= 1'b0;
                r_pwmPeriod    <= '0;
                r_pwmCompare   <= '0;
            end else begin
                case (r_state)
                    S_RESET: r_state <= S_IDLE;
                    S_IDLE: begin
                        if (ramp_command) begin
                            r_state <= S_ACCEPT;
                        end else if (r_dirty) begin
                            r_state      <= S_PUSH;
                            r_pwmCommand <= 1'b1;
                            r_pwmPeriod  <= r_period;
                            r_pwmCompare <= r_current;
                        end else if (r_tickPending) begin
                            if (r_current != r_target) begin
                                r_state <= S_STEP;
                            end else begin
                                r_tickPending <= 1'b0;
                            end
                        end
                    end
                    S_ACCEPT: begin
                        r_target       <= ramp_target;
                        r_step         <= ramp_step;
                        r_period       <= ramp_period;
                        if (ramp_period != r_period) begin
                            r_dirty <= 1'b1;
                        end
                        r_rampResponse <= 1'b1;
                        r_state        <= S_RESP;
                    end
                    S_RESP: begin
                        if (!ramp_command) begin
                            r_rampResponse <= 1'b0;
                            r_state        <= S_IDLE;
                        end
                    end
                    S_STEP: begin
                        r_tickPending <= 1'b0;
                        r_current     <= w_nextCurrent;
                        r_pwmCommand  <= 1'b1;
                        r_pwmPeriod   <= r_period;
                        r_pwmCompare  <= w_nextCurrent;
                        r_state       <= S_PUSH;
                    end
                    S_PUSH: begin
                        if (pwm_response) begin
                            r_dirty       <= 1'b0;
                            r_pwmCommand  <= 1'b0;
                            r_rampCurrent <= r_pwmCompare;
                            r_state       <= S_RELEASE;
                        end
                    end
                    S_RELEASE: begin
                        if (!pwm_response) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase

                // Placed after the FSM so a wrap on the same cycle as a clear re-arms the tick.
                if (r_state != S_RESET) begin
                    if (r_tickCount == TICK_LAST) begin
                        r_tickCount   <= '0;
                        r_tickPending <= 1'b1;
                    end else begin
                        r_tickCount <= r_tickCount + CW'(1);
                    end
                end
            end
        end
    end

    assign ramp_response = r_rampResponse;
    assign ramp_current  = r_rampCurrent;
    assign pwm_command   = r_pwmCommand;
    assign pwm_period    = r_pwmPeriod;
    assign pwm_compare   = r_pwmCompare;
    assign ramp_busy     = (r_current != r_target) | r_dirty |
                           (r_state == S_STEP) | (r_state == S_PUSH) | (r_state == S_RELEASE);

endmodule

// File: tb/tb_servo_ramp.sv
// Scoreboard bench for servo_ramp: expected pwm pushes are queued per command and
// checked by a pwm-side responder when each push is observed.
module tb_servo_ramp;

    typedef struct packed {
        logic [31:0] period;
        logic [31:0] compare;
    } pushT;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clock_valid = 1'b1;
    logic        ramp_command = 1'b0;
    logic        ramp_response;
    logic [31:0] ramp_target = '0;
    logic [31:0] ramp_step = '0;
    logic [31:0] ramp_period = '0;
    logic [31:0] ramp_current;
    logic        ramp_busy;
    logic        pwm_command;
    logic        pwm_response = 1'b0;
    logic [31:0] pwm_period;
    logic [31:0] pwm_compare;

    int          vectorsApplied = 0;
    int          miscompares = 0;
    int          unexpectedPushes = 0;
    int          holdReq = 0;
    pushT        expQ[$];
    logic [31:0] mCur = '0;
    logic [31:0] mPeriod = '0;

    servo_ramp #(.UPDATE_CYCLES(4)) dut (
        .clock(clock),
        .reset(reset),
        .clock_valid(clock_valid),
        .ramp_command(ramp_command),
        .ramp_response(ramp_response),
        .ramp_target(ramp_target),
        .ramp_step(ramp_step),
        .ramp_period(ramp_period),
        .ramp_current(ramp_current),
        .ramp_busy(ramp_busy),
        .pwm_command(pwm_command),
        .pwm_response(pwm_response),
        .pwm_period(pwm_period),
        .pwm_compare(pwm_compare)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectorsApplied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Reference ramp: overshoot is detected with 33-bit sums rather than a distance.
    task automatic queueRamp(input logic [31:0] t, input logic [31:0] s, input logic [31:0] p);
        logic [32:0] sum;
        if (p != mPeriod) begin
            expQ.push_back({p, mCur});
            mPeriod = p;
        end
        while (mCur != t) begin
            if (t > mCur) begin
                sum = {1'b0, mCur} + {1'b0, s};
                mCur = (s == 32'd0 || sum >= {1'b0, t}) ? t : sum[31:0];
            end else begin
                sum = {1'b0, t} + {1'b0, s};
                mCur = (s == 32'd0 || {1'b0, mCur} <= sum) ? t : (mCur - s);
            end
            expQ.push_back({p, mCur});
        end
    endtask

    task automatic sendCommand(input logic [31:0] t, input logic [31:0] s, input logic [31:0] p);
        int n;
        @(negedge clock);
        ramp_target = t;
        ramp_step = s;
        ramp_period = p;
        ramp_command = 1'b1;
        n = 0;
        while (!ramp_response && n < 300) begin @(negedge clock); n++; end
        checkOutput("ackRise", 32'(ramp_response), 32'd1);
        ramp_command = 1'b0;
        n = 0;
        while (ramp_response && n < 300) begin @(negedge clock); n++; end
        checkOutput("ackFall", 32'(ramp_response), 32'd0);
    endtask

    task automatic applyStimulus(input logic [31:0] t, input logic [31:0] s, input logic [31:0] p);
        queueRamp(t, s, p);
        sendCommand(t, s, p);
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        @(negedge clock);
        while ((ramp_busy || pwm_command || expQ.size() != 0) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        checkOutput(tag, 32'(n >= 2000), 32'd0);
    endtask

    // pwm-side model: pops the expected pair on the first cycle of each push and holds it stable.
    initial begin
        pushT cur;
        bit   inPush;
        bit   haveExp;
        int   waited;
        inPush = 0;
        haveExp = 0;
        waited = 0;
        cur = '0;
        forever begin
            @(negedge clock);
            if (pwm_command && !pwm_response) begin
                if (!inPush) begin
                    inPush = 1;
                    waited = 0;
                    haveExp = (expQ.size() != 0);
                    if (haveExp) cur = expQ.pop_front();
                    else unexpectedPushes++;
                end
                if (haveExp) begin
                    checkOutput("pwmPeriod", pwm_period, cur.period);
                    checkOutput("pwmCompare", pwm_compare, cur.compare);
                end
                if (waited >= holdReq) begin
                    pwm_response = 1'b1;
                    holdReq = 0;
                end else begin
                    waited++;
                end
            end else if (!pwm_command) begin
                pwm_response = 1'b0;
                inPush = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        repeat (3) @(negedge clock);
        checkOutput("rstPwmCmd", 32'(pwm_command), 32'd0);
        checkOutput("rstResp", 32'(ramp_response), 32'd0);
        checkOutput("rstCurrent", ramp_current, 32'd0);
        checkOutput("rstBusy", 32'(ramp_busy), 32'd0);
        checkOutput("rstPeriod", pwm_period, 32'd0);
        checkOutput("rstCompare", pwm_compare, 32'd0);
        reset = 1'b0;

        applyStimulus(32'd10, 32'd3, 32'd100);
        waitIdle("rampUpIdle");
        checkOutput("rampUpCurrent", ramp_current, 32'd10);
        checkOutput("rampUpBusy", 32'(ramp_busy), 32'd0);

        applyStimulus(32'd2, 32'd4, 32'd100);
        waitIdle("rampDownIdle");
        checkOutput("rampDownCurrent", ramp_current, 32'd2);

        applyStimulus(32'd0, 32'd0, 32'd100);
        waitIdle("jumpZeroIdle");
        applyStimulus(32'hFFFF_FFF0, 32'd0, 32'd100);
        waitIdle("jumpHighIdle");
        checkOutput("jumpHighCurrent", ramp_current, 32'hFFFF_FFF0);
        applyStimulus(32'd5, 32'd0, 32'd100);
        waitIdle("jumpLowIdle");
        checkOutput("jumpLowCurrent", ramp_current, 32'd5);

        applyStimulus(32'd5, 32'd7, 32'd100);
        repeat (20) @(negedge clock);
        checkOutput("noPushBusy", 32'(ramp_busy), 32'd0);
        checkOutput("noPushCmd", 32'(pwm_command), 32'd0);

        applyStimulus(32'd5, 32'd1, 32'd200);
        waitIdle("periodOnlyIdle");

        // Direction reversal mid-ramp: the upward ramp is cut short at 15.
        expQ.push_back({32'd200, 32'd10});
        expQ.push_back({32'd200, 32'd15});
        sendCommand(32'd100, 32'd5, 32'd200);
        n = 0;
        while (ramp_current != 32'd15 && n < 300) begin @(negedge clock); n++; end
        checkOutput("reverseReach", ramp_current, 32'd15);
        mCur = 32'd15;
        applyStimulus(32'd0, 32'd5, 32'd200);
        waitIdle("reverseIdle");
        checkOutput("reverseCurrent", ramp_current, 32'd0);

        holdReq = 20;
        applyStimulus(32'd9, 32'd0, 32'd200);
        n = 0;
        while (!pwm_command && n < 300) begin @(negedge clock); n++; end
        checkOutput("holdCmdRise", 32'(pwm_command), 32'd1);
        queueRamp(32'd7, 32'd1, 32'd200);
        ramp_target = 32'd7;
        ramp_step = 32'd1;
        ramp_period = 32'd200;
        ramp_command = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            checkOutput("holdRespLow", 32'(ramp_response), 32'd0);
            checkOutput("holdCmdHigh", 32'(pwm_command), 32'd1);
        end
        n = 0;
        while (!ramp_response && n < 300) begin @(negedge clock); n++; end
        checkOutput("holdAckRise", 32'(ramp_response), 32'd1);
        checkOutput("holdAckNoPush", 32'(pwm_command), 32'd0);
        ramp_command = 1'b0;
        waitIdle("holdIdle");
        checkOutput("holdCurrent", ramp_current, 32'd7);

        holdReq = 50;
        applyStimulus(32'd20, 32'd0, 32'd200);
        n = 0;
        while (!pwm_command && n < 300) begin @(negedge clock); n++; end
        checkOutput("midPushCmd", 32'(pwm_command), 32'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("resetPushCmd", 32'(pwm_command), 32'd0);
        checkOutput("resetPushCompare", pwm_compare, 32'd0);
        checkOutput("resetPushCurrent", ramp_current, 32'd0);
        checkOutput("resetPushPeriod", pwm_period, 32'd0);
        checkOutput("resetQueue", 32'(expQ.size()), 32'd0);
        holdReq = 0;
        mCur = '0;
        mPeriod = '0;
        @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        checkOutput("postResetBusy", 32'(ramp_busy), 32'd0);
        checkOutput("postResetCmd", 32'(pwm_command), 32'd0);
        applyStimulus(32'd2, 32'd0, 32'd50);
        waitIdle("postResetIdle");
        checkOutput("postResetCurrent", ramp_current, 32'd2);

        @(negedge clock);
        clock_valid = 1'b0;
        reset = 1'b1;
        repeat (10) begin
            @(negedge clock);
            checkOutput("gatedCurrent", ramp_current, 32'd2);
            checkOutput("gatedPeriod", pwm_period, 32'd50);
        end
        clock_valid = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("ungatedCurrent", ramp_current, 32'd0);
        checkOutput("ungatedPeriod", pwm_period, 32'd0);
        checkOutput("ungatedCompare", pwm_compare, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        checkOutput("unexpectedPushes", 32'(unexpectedPushes), 32'd0);
        checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule

// File: doc/servo_ramp.md
Name: servo_ramp

Overview:
- E100-facing servo motion sequencer that sits directly upstream of the pwm block.
- Accepts a target compare value, a step size and a period from the E100 over a four-phase command/response handshake.
- Every UPDATE_CYCLES clocks it moves its current compare one step toward the target.
- It pushes each new period/compare pair into the pwm block through that block's own four-phase handshake, giving smooth servo motion with no per-step CPU writes.

Parameters:
UPDATE_CYCLES, 50000, clocks between ramp steps (1 ms at 50 MHz); legal range >= 2.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
clock_valid  input  1  clock enable; when low every register holds, including through reset
ramp_command  input  1  E100 write request, four-phase
ramp_response  output  1  E100 acknowledge
ramp_target  input  32  requested final compare value, unsigned
ramp_step  input  32  compare increment per update; 0 means jump to target
ramp_period  input  32  PWM period forwarded to pwm
ramp_current  output  32  compare value most recently committed to pwm
ramp_busy  output  1  high while current != target or a push is pending or in flight
pwm_command  output  1  to pwm_command of the pwm block
pwm_response  input  1  from pwm_response of the pwm block
pwm_period  output  32  to pwm_period
pwm_compare  output  32  to pwm_compare

Behaviour:
- All state updates on posedge clock, and only when clock_valid=1. reset is evaluated only when clock_valid=1 and has priority over everything else.
- Reset values: all outputs 0. Internal current, target, step, period, tick counter, tick_pending and dirty are all 0. State = S_RESET.
- Tick counter counts 0..UPDATE_CYCLES-1 and wraps to 0. On the wrap cycle it sets tick_pending. It free-runs in every state except S_RESET.
- States and transitions:
  - S_RESET: go to S_IDLE next cycle.
  - S_IDLE, checked in priority order:
    1. ramp_command=1 -> S_ACCEPT.
    2. Else dirty=1 -> S_PUSH.
    3. Else tick_pending=1 and current!=target -> S_STEP.
    4. Else tick_pending=1 and current==target -> clear tick_pending, stay in S_IDLE.
  - S_ACCEPT: latch ramp_target, ramp_step and ramp_period. Set dirty=1 if ramp_period differs from the latched period. Go to S_RESP.
  - S_RESP: ramp_response=1. Stay while ramp_command=1; go to S_IDLE when it is 0. ramp_response is registered and drops the cycle after leaving S_RESP.
  - S_STEP: clear tick_pending and compute the new current:
    - If step=0 or |target-current| <= step, current=target.
    - Else current = current+step when target>current, or current-step when target<current.
    - The comparison is done on the unsigned difference (larger minus smaller), so no 32-bit overflow or underflow is possible.
    - Go to S_PUSH.
  - S_PUSH: drive pwm_period=period and pwm_compare=current, hold pwm_command=1. When pwm_response=1, clear dirty and go to S_RELEASE. ramp_current updates on entry to S_RELEASE.
  - S_RELEASE: pwm_command=0. When pwm_response=0, go to S_IDLE.
- pwm_period and pwm_compare are stable from the first S_PUSH cycle until S_RELEASE is exited.
- The pwm block samples them one cycle after pwm_command rises.
- Latency: a tick in S_IDLE leads to pwm_command rising 2 cycles later (S_STEP, then S_PUSH).
- ramp_busy = (current!=target) | dirty | state in {S_STEP, S_PUSH, S_RELEASE}.
- Boundary and simultaneous cases:
  - ramp_command arriving during S_STEP, S_PUSH or S_RELEASE is not acknowledged until the return to S_IDLE; no request is dropped.
  - ramp_command and tick_pending together in S_IDLE: the command wins and the tick stays pending.
  - Ticks that occur while busy collapse into a single pending tick; at most one step per return to S_IDLE.
  - A new target opposite to the current direction reverses direction on the next step.
  - target==current on accept with an unchanged period: no push.
  - Reset mid-handshake: pwm_command and ramp_response drop the next enabled cycle, and the block restarts from S_RESET. It does not wait for pwm_response.

Test Plan:
- UPDATE_CYCLES=4. After reset, write target=10, step=3, period=100 -> dirty push (100,0), then pushes of compare 3, 6, 9, 10 on successive ticks. ramp_busy falls after the push of 10 completes.
- current=10, write target=2, step=4 -> pushes of 6 then 2. No underflow. ramp_current ends at 2.
- step=0, current=0, target=0xFFFFFFF0 -> a single push of 0xFFFFFFF0 on the next tick.
- Hold pwm_response low for 20 cycles while pwm_command=1, and raise ramp_command meanwhile -> pwm_compare stays stable and ramp_response stays 0 until the pwm handshake finishes and S_IDLE is re-entered.
- Assert reset during S_PUSH -> the next cycle has pwm_command=0, pwm_compare=0 and ramp_current=0, and the state returns to idle.
- clock_valid=0 for 10 cycles with reset=1 -> no state change. After clock_valid returns to 1, reset is applied.
